// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Also holds the grant/state encodings and the IO-space address decode.
package dmem_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned IO_SEL_BIT = 7;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_DMA  = 2'd2
   } gnt_e;

   typedef enum logic {
      D_IDLE = 1'b0,
      D_ACK  = 1'b1
   } dstate_e;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } mem_req_t;

   // Addresses with the IO select bit set belong to the IO block, not RAM.
   function automatic logic is_io(input logic [XLEN-1:0] addr);
      return addr[IO_SEL_BIT];
   endfunction

endpackage

// File: rtl/dmem_grant_logic.sv
// Combinational grant decision and memory-port mux between the pipeline and DMA ports.
// Reset forces a NONE grant so no write or stall escapes while the block is held in reset.
module dmem_grant_logic
   import dmem_pkg::*;
(
   input  logic     reset,
   input  logic     dma_idle,
   input  logic     at_limit,
   input  logic     p_req,
   input  mem_req_t p_bus,
   input  logic     d_req,
   input  mem_req_t d_bus,
   output gnt_e     gnt_c,
   output mem_req_t m_bus_c,
   output logic     p_stall_c
);

   // Pipeline has priority unless the DMA port has waited the full starvation budget.
   always_comb begin
      gnt_c           = GNT_NONE;
      m_bus_c.we      = 1'b0;
      m_bus_c.addr    = p_bus.addr;
      m_bus_c.wdata   = p_bus.wdata;
      p_stall_c       = 1'b0;

      if (!reset) begin
         if (dma_idle && d_req && (!p_req || at_limit)) begin
            gnt_c = GNT_DMA;
         end else if (p_req) begin
            gnt_c = GNT_PIPE;
         end
      end

      case (gnt_c)
         GNT_PIPE: begin
            m_bus_c = p_bus;
         end
         GNT_DMA: begin
            m_bus_c.addr  = d_bus.addr;
            m_bus_c.wdata = d_bus.wdata;
            // DMA writes into IO space are dropped and reported through d_err.
            m_bus_c.we    = d_bus.we & ~is_io(d_bus.addr);
            p_stall_c     = p_req;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port arbiter sharing the data-memory/IO block between the MEM stage and a DMA word port.
// Holds the DMA handshake FSM, the starvation counter and the registered DMA response.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            p_req,
   input  logic            p_we,
   input  logic [XLEN-1:0] p_addr,
   input  logic [XLEN-1:0] p_wdata,
   output logic            p_stall,
   output logic [XLEN-1:0] p_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic            d_ack,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_err,
   output logic            m_we,
   output logic [XLEN-1:0] m_addr,
   output logic [XLEN-1:0] m_wdata,
   input  logic [XLEN-1:0] m_rdata
);

   dstate_e          d_state;
   dstate_e          d_state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   gnt_e             gnt;
   mem_req_t         p_bus;
   mem_req_t         d_bus;
   mem_req_t         m_bus;
   logic             at_limit;
   logic             dma_idle;
   logic             dma_eligible;
   logic             dma_gnt;
   logic             pipe_gnt;

   assign p_bus        = '{we: p_we, addr: p_addr, wdata: p_wdata};
   assign d_bus        = '{we: d_we, addr: d_addr, wdata: d_wdata};
   assign at_limit     = (starve_cnt == CNT_W'(STARVE_LIMIT));
   assign dma_idle     = (d_state == D_IDLE);
   assign dma_eligible = dma_idle & d_req;
   assign dma_gnt      = (gnt == GNT_DMA);
   assign pipe_gnt     = (gnt == GNT_PIPE);

   dmem_grant_logic u_grant (
      .reset     (reset),
      .dma_idle  (dma_idle),
      .at_limit  (at_limit),
      .p_req     (p_req),
      .p_bus     (p_bus),
      .d_req     (d_req),
      .d_bus     (d_bus),
      .gnt_c     (gnt),
      .m_bus_c   (m_bus),
      .p_stall_c (p_stall)
   );

   assign m_we    = m_bus.we;
   assign m_addr  = m_bus.addr;
   assign m_wdata = m_bus.wdata;
   assign p_rdata = m_rdata;

   // DMA FSM and starvation counter, next-state logic.
   always_comb begin
      d_state_nxt = d_state;
      cnt_nxt     = starve_cnt;

      case (d_state)
         D_IDLE:  if (dma_gnt) d_state_nxt = D_ACK;
         D_ACK:   d_state_nxt = D_IDLE;
         default: d_state_nxt = D_IDLE;
      endcase

      // Counter saturates at the limit; a dropped request forgets any accumulated wait.
      if (dma_gnt || !d_req) begin
         cnt_nxt = '0;
      end else if (pipe_gnt && dma_eligible && !at_limit) begin
         cnt_nxt = starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         d_state    <= D_IDLE;
         starve_cnt <= '0;
      end else begin
         d_state    <= d_state_nxt;
         starve_cnt <= cnt_nxt;
      end
   end

   // DMA response: ack and error pulse one cycle after service, read data held until the next service.
   always_ff @(posedge clock) begin
      if (reset) begin
         d_ack   <= 1'b0;
         d_err   <= 1'b0;
         d_rdata <= '0;
      end else begin
         d_ack <= dma_gnt;
         d_err <= dma_gnt & d_we & is_io(d_addr);
         if (dma_gnt) d_rdata <= m_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences and a random run
// against a cycle-level reference model with its own shadow memory.
module tb_dmem_arbiter;

   localparam int unsigned LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        p_req, p_we, d_req, d_we;
   logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
   logic        p_stall, d_ack, d_err, m_we;
   logic [31:0] p_rdata, d_rdata, m_addr, m_wdata, m_rdata;

   int total = 0;
   int bad   = 0;

   // Environment memory: 16 RAM words plus one IO register, with a bench-side preload path.
   logic [31:0] ram [16];
   logic [31:0] out_port0;
   logic        pre_we = 1'b0;
   logic [4:0]  pre_idx;
   logic [31:0] pre_val;

   always #5 clock = ~clock;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clock(clock), .reset(reset),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_stall(p_stall), .p_rdata(p_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   always_comb m_rdata = m_addr[7] ? out_port0 : ram[m_addr[5:2]];

   always @(posedge clock) begin
      if (pre_we) begin
         if (pre_idx[4]) out_port0 <= pre_val;
         else            ram[pre_idx[3:0]] <= pre_val;
      end else if (m_we) begin
         if (m_addr[7]) out_port0 <= m_wdata;
         else           ram[m_addr[5:2]] <= m_wdata;
      end
   end

   typedef struct {
      logic        rst, preq, pwe;
      logic [31:0] paddr;
      logic        dreq, dwe;
      logic [31:0] daddr;
      logic        e_mwe;
      logic [31:0] e_maddr, e_mwdata;
      logic        e_stall, e_ack, e_err;
   } vec_t;

   vec_t tbl [11];

   // Reference model state
   logic [31:0] sram [16];
   logic [31:0] sio;
   logic        exp_ack, exp_err;
   logic [31:0] exp_rdata;
   int          waited;

   function automatic vec_t mk(input logic rst, preq, pwe, input logic [31:0] paddr,
                               input logic dreq, dwe, input logic [31:0] daddr,
                               input logic e_mwe, input logic [31:0] e_maddr, e_mwdata,
                               input logic e_stall, e_ack, e_err);
      vec_t v;
      v.rst = rst; v.preq = preq; v.pwe = pwe; v.paddr = paddr;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr;
      v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
      v.e_stall = e_stall; v.e_ack = e_ack; v.e_err = e_err;
      return v;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return a[7] ? sio : sram[a[5:2]];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic drive(input logic rst, preq, pwe, input logic [31:0] paddr, pwdata,
                        input logic dreq, dwe, input logic [31:0] daddr, dwdata);
      reset = rst; p_req = preq; p_we = pwe; p_addr = paddr; p_wdata = pwdata;
      d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic preload(input logic [4:0] idx, input logic [31:0] val);
      pre_we = 1'b1; pre_idx = idx; pre_val = val;
      step();
      pre_we = 1'b0;
   endtask

   // One random cycle: drive, compare against the model at the falling edge, advance the model.
   task automatic rand_cycle();
      logic        eligible, dma, pipe, e_we;
      logic [31:0] ea, ew;
      if (!(d_req && !exp_ack)) begin
         d_req   = ($urandom_range(0, 2) == 0);
         d_we    = 1'($urandom);
         d_addr  = $urandom & 32'h0000_00BC;
         d_wdata = $urandom;
      end
      p_req   = ($urandom_range(0, 3) != 0);
      p_we    = 1'($urandom);
      p_addr  = $urandom & 32'h0000_00BC;
      p_wdata = $urandom;
      @(negedge clock);
      eligible = !exp_ack && d_req;
      dma      = eligible && (!p_req || waited == LIMIT);
      pipe     = !dma && p_req;
      ea       = dma ? d_addr  : p_addr;
      ew       = dma ? d_wdata : p_wdata;
      e_we     = dma ? (d_we && !d_addr[7]) : (pipe && p_we);
      chk("rnd_ack",   32'(d_ack),   32'(exp_ack));
      chk("rnd_err",   32'(d_err),   32'(exp_err));
      chk("rnd_rdata", d_rdata,      exp_rdata);
      chk("rnd_maddr", m_addr,       ea);
      chk("rnd_mwd",   m_wdata,      ew);
      chk("rnd_mwe",   32'(m_we),    32'(e_we));
      chk("rnd_stall", 32'(p_stall), 32'(dma && p_req));
      chk("rnd_prd",   p_rdata,      model_rd(ea));
      exp_ack = dma;
      exp_err = dma && d_we && d_addr[7];
      if (dma) exp_rdata = model_rd(d_addr);
      if (dma || !d_req) waited = 0;
      else if (pipe && eligible && waited < LIMIT) waited++;
      if (e_we) begin
         if (ea[7]) sio = ew;
         else       sram[ea[5:2]] = ew;
      end
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      for (int i = 0; i < 16; i++) preload(5'(i), 32'h0101_0101 * 32'(i));
      preload(5'd16, 32'hA5A5_A5A5);
      @(negedge clock);
      chk("rst_ack",   32'(d_ack),   0);
      chk("rst_err",   32'(d_err),   0);
      chk("rst_rdata", d_rdata,      0);
      chk("rst_mwe",   32'(m_we),    0);
      chk("rst_stall", 32'(p_stall), 0);
      step();

      // Starvation sequence with limit 4, IO write drop and a plain pipe store.
      tbl[0]  = mk(1, 1, 1, 32'h0C, 1, 1, 32'h08, 0, 32'h0C, 32'h1111, 0, 0, 0);
      for (int i = 1; i < 5; i++)
         tbl[i] = mk(0, 1, 0, 32'h0C, 1, 1, 32'h08, 0, 32'h0C, 32'h1111, 0, 0, 0);
      tbl[5]  = mk(0, 1, 0, 32'h0C, 1, 1, 32'h08, 1, 32'h08, 32'h55,   1, 0, 0);
      tbl[6]  = mk(0, 1, 0, 32'h0C, 1, 1, 32'h08, 0, 32'h0C, 32'h1111, 0, 1, 0);
      tbl[7]  = mk(0, 1, 0, 32'h0C, 0, 1, 32'h08, 0, 32'h0C, 32'h1111, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 32'h0C, 1, 1, 32'h80, 0, 32'h80, 32'h55,   0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 32'h0C, 0, 0, 32'h80, 0, 32'h0C, 32'h1111, 0, 1, 1);
      tbl[10] = mk(0, 1, 1, 32'h04, 0, 0, 32'h80, 1, 32'h04, 32'h1111, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rst, tbl[i].preq, tbl[i].pwe, tbl[i].paddr, 32'h1111,
               tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, 32'h55);
         @(negedge clock);
         chk($sformatf("v%0d_mwe", i),   32'(m_we),    32'(tbl[i].e_mwe));
         chk($sformatf("v%0d_maddr", i), m_addr,       tbl[i].e_maddr);
         chk($sformatf("v%0d_mwd", i),   m_wdata,      tbl[i].e_mwdata);
         chk($sformatf("v%0d_stall", i), 32'(p_stall), 32'(tbl[i].e_stall));
         chk($sformatf("v%0d_ack", i),   32'(d_ack),   32'(tbl[i].e_ack));
         chk($sformatf("v%0d_err", i),   32'(d_err),   32'(tbl[i].e_err));
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      chk("ram2_dma_write", ram[2],    32'h55);
      chk("io_untouched",   out_port0, 32'hA5A5_A5A5);
      chk("ram1_pipe",      ram[1],    32'h1111);
      step();

      // Idle pipeline: DMA read served at once, data one cycle later.
      preload(5'd4, 32'hDEAD_BEEF);
      drive(0, 0, 0, 0, 0, 1, 0, 32'h10, 0);
      @(negedge clock);
      chk("a_maddr", m_addr, 32'h10);
      chk("a_stall", 32'(p_stall), 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      chk("a_ack",   32'(d_ack), 1);
      chk("a_rdata", d_rdata, 32'hDEAD_BEEF);
      chk("a_stall2", 32'(p_stall), 0);
      step();

      // DMA read at limit races a pipe store to the same word: DMA sees the old value.
      preload(5'd1, 32'h1234);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 32'h20, 0, 1, 0, 32'h04, 0);
         @(negedge clock);
         chk($sformatf("b_wait%0d_stall", i), 32'(p_stall), 0);
         chk($sformatf("b_wait%0d_maddr", i), m_addr, 32'h20);
         step();
      end
      drive(0, 1, 1, 32'h04, 32'h9999, 1, 0, 32'h04, 0);
      @(negedge clock);
      chk("b_srv_stall", 32'(p_stall), 1);
      chk("b_srv_mwe",   32'(m_we), 0);
      chk("b_srv_prd",   p_rdata, 32'h1234);
      step();
      drive(0, 1, 1, 32'h04, 32'h9999, 0, 0, 32'h04, 0);
      @(negedge clock);
      chk("b_ack",   32'(d_ack), 1);
      chk("b_rdata", d_rdata, 32'h1234);
      chk("b_mwe",   32'(m_we), 1);
      chk("b_stall", 32'(p_stall), 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      chk("b_ram1", ram[1], 32'h9999);
      step();

      // Reset right after service: response cleared, held request served again afterwards.
      drive(0, 0, 0, 32'h0C, 0, 1, 0, 32'h10, 0);
      @(negedge clock);
      chk("c_maddr", m_addr, 32'h10);
      step();
      drive(1, 1, 1, 32'h0C, 32'h7777, 1, 0, 32'h10, 0);
      @(negedge clock);
      chk("c_rst_mwe",   32'(m_we), 0);
      chk("c_rst_stall", 32'(p_stall), 0);
      step();
      @(negedge clock);
      chk("c_rst_ack",   32'(d_ack), 0);
      chk("c_rst_err",   32'(d_err), 0);
      chk("c_rst_rdata", d_rdata, 0);
      step();
      drive(0, 0, 0, 32'h0C, 0, 1, 0, 32'h10, 0);
      @(negedge clock);
      chk("c_resrv_maddr", m_addr, 32'h10);
      step();
      drive(0, 0, 0, 32'h0C, 0, 0, 0, 0, 0);
      @(negedge clock);
      chk("c_ack",   32'(d_ack), 1);
      chk("c_rdata", d_rdata, 32'hDEAD_BEEF);
      step();

      // Random run against the reference model from a fresh reset and known memory image.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         sram[i] = $urandom;
         preload(5'(i), sram[i]);
      end
      sio = $urandom;
      preload(5'd16, sio);
      exp_ack = 1'b0; exp_err = 1'b0; exp_rdata = '0; waited = 0;
      reset = 1'b0;
      for (int n = 0; n < 2000; n++) rand_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
